// File: rtl/snoop_pkg.sv
// rtl/snoop_pkg.sv - shared word fields, encodings and controller states for the snooping bus
package snoop_pkg;

    localparam int WORD_W     = 12;
    localparam int OP_BIT     = 11;
    localparam int SUPPLY_BIT = 10;
    localparam int STATE_HI   = 9;
    localparam int STATE_LO   = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        COH_INVALID   = 2'b00,
        COH_SHARED    = 2'b01,
        COH_EXCLUSIVE = 2'b10,
        COH_MODIFIED  = 2'b11
    } coh_state_e;

    localparam logic [1:0] PROC_NONE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SNOOP,
        ST_MEM,
        ST_RESP,
        ST_DONE
    } ctrl_state_e;

    // The owner never supplies its own request, whatever its snoop word says.
    function automatic logic can_supply(input logic [WORD_W-1:0] word,
                                        input logic [1:0]        idx,
                                        input logic [1:0]        owner);
        return word[SUPPLY_BIT]
            && (coh_state_e'(word[STATE_HI:STATE_LO]) != COH_INVALID)
            && (idx != owner);
    endfunction

    function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
        logic [1:0] id;
        id = PROC_NONE;
        if (oh[0])      id = 2'd0;
        else if (oh[1]) id = 2'd1;
        else if (oh[2]) id = 2'd2;
        return id;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - combinational three-way round-robin arbiter, search starts after last
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        case (last)
            2'd0: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd1: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// rtl/snoop_bus_ctrl.sv - snooping bus sequencer/arbiter; SNOOP_BUS_TIMEOUT_EN adds a memory wait timeout
module snoop_bus_ctrl #(
    parameter int SNOOP_LAT   = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [11:0] req_msg0,
    input  logic [11:0] req_msg1,
    input  logic [11:0] req_msg2,
    input  logic [11:0] snoop0,
    input  logic [11:0] snoop1,
    input  logic [11:0] snoop2,
    input  logic [11:0] mem_data,
    input  logic        mem_ready,
    output logic [2:0]  gnt,
    output logic [1:0]  processor,
    output logic [11:0] cmd,
    output logic        cmd_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic        resp_valid,
    output logic [11:0] resp_data,
    output logic [1:0]  resp_src,
    output logic        resp_err
);
    import snoop_pkg::*;

    ctrl_state_e state, state_nxt;
    logic [1:0]  last, last_nxt;
    logic [2:0]  snoop_cnt, snoop_cnt_nxt;
    logic [2:0]  gnt_nxt;
    logic [1:0]  processor_nxt;
    logic [11:0] cmd_nxt;
    logic        cmd_valid_nxt, mem_req_nxt, mem_we_nxt, resp_valid_nxt;
    logic [11:0] resp_data_nxt;
    logic [1:0]  resp_src_nxt;
    logic [2:0]  win;
    logic [11:0] win_msg;
    logic [2:0]  supply;

`ifdef SNOOP_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic          resp_err_q, resp_err_nxt;
    assign resp_err = resp_err_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign resp_err = 1'b0;
`endif

    rr_arbiter3 u_arb (
        .req  (req),
        .last (last),
        .gnt  (win)
    );

    always_comb begin
        win_msg = req_msg0;
        if (win[1])      win_msg = req_msg1;
        else if (win[2]) win_msg = req_msg2;
    end

    assign supply = {can_supply(snoop2, 2'd2, processor),
                     can_supply(snoop1, 2'd1, processor),
                     can_supply(snoop0, 2'd0, processor)};

    always_comb begin
        state_nxt      = state;
        last_nxt       = last;
        snoop_cnt_nxt  = snoop_cnt;
        gnt_nxt        = gnt;
        processor_nxt  = processor;
        cmd_nxt        = cmd;
        cmd_valid_nxt  = 1'b0;
        mem_req_nxt    = mem_req;
        mem_we_nxt     = mem_we;
        resp_valid_nxt = 1'b0;
        resp_data_nxt  = resp_data;
        resp_src_nxt   = resp_src;
`ifdef SNOOP_BUS_TIMEOUT_EN
        tmo_cnt_nxt    = tmo_cnt;
        resp_err_nxt   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt     = ST_GRANT;
                    gnt_nxt       = win;
                    processor_nxt = onehot_to_id(win);
                    cmd_nxt       = win_msg;
                    cmd_valid_nxt = 1'b1;
                end
            end
            ST_GRANT: begin
                state_nxt     = ST_SNOOP;
                snoop_cnt_nxt = '0;
            end
            ST_SNOOP: begin
                if (snoop_cnt == 3'(SNOOP_LAT - 1)) begin
`ifdef SNOOP_BUS_TIMEOUT_EN
                    tmo_cnt_nxt = '0;
`endif
                    // Writes always go to memory; snoop results only matter for reads.
                    if (cmd[OP_BIT] == OP_WRITE) begin
                        state_nxt   = ST_MEM;
                        mem_req_nxt = 1'b1;
                        mem_we_nxt  = 1'b1;
                    end else if (|supply) begin
                        state_nxt      = ST_RESP;
                        resp_valid_nxt = 1'b1;
                        if (supply[0]) begin
                            resp_data_nxt = snoop0;
                            resp_src_nxt  = 2'd0;
                        end else if (supply[1]) begin
                            resp_data_nxt = snoop1;
                            resp_src_nxt  = 2'd1;
                        end else begin
                            resp_data_nxt = snoop2;
                            resp_src_nxt  = 2'd2;
                        end
                    end else begin
                        state_nxt   = ST_MEM;
                        mem_req_nxt = 1'b1;
                        mem_we_nxt  = 1'b0;
                    end
                end else begin
                    snoop_cnt_nxt = snoop_cnt + 3'd1;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_nxt      = ST_RESP;
                    mem_req_nxt    = 1'b0;
                    mem_we_nxt     = 1'b0;
                    resp_valid_nxt = 1'b1;
                    resp_data_nxt  = mem_we ? cmd : mem_data;
                    resp_src_nxt   = PROC_NONE;
                end
`ifdef SNOOP_BUS_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    state_nxt      = ST_RESP;
                    mem_req_nxt    = 1'b0;
                    mem_we_nxt     = 1'b0;
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b1;
                    resp_data_nxt  = '0;
                    resp_src_nxt   = PROC_NONE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_nxt     = ST_DONE;
                gnt_nxt       = '0;
                processor_nxt = PROC_NONE;
                last_nxt      = processor;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last       <= 2'd2;
            snoop_cnt  <= '0;
            gnt        <= '0;
            processor  <= PROC_NONE;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_src   <= '0;
`ifdef SNOOP_BUS_TIMEOUT_EN
            tmo_cnt    <= '0;
            resp_err_q <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            snoop_cnt  <= snoop_cnt_nxt;
            gnt        <= gnt_nxt;
            processor  <= processor_nxt;
            cmd        <= cmd_nxt;
            cmd_valid  <= cmd_valid_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            resp_valid <= resp_valid_nxt;
            resp_data  <= resp_data_nxt;
            resp_src   <= resp_src_nxt;
`ifdef SNOOP_BUS_TIMEOUT_EN
            tmo_cnt    <= tmo_cnt_nxt;
            resp_err_q <= resp_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb/tb_snoop_bus_ctrl.sv - randomized self-checking bench for snoop_bus_ctrl against a transaction-level model
module tb_snoop_bus_ctrl;

    localparam int LAT = 1;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [11:0] req_msg0, req_msg1, req_msg2;
    logic [11:0] snoop0, snoop1, snoop2;
    logic [11:0] mem_data;
    logic        mem_ready;
    logic [2:0]  gnt;
    logic [1:0]  processor;
    logic [11:0] cmd;
    logic        cmd_valid, mem_req, mem_we, resp_valid;
    logic [11:0] resp_data;
    logic [1:0]  resp_src;
    logic        resp_err;

    int errors = 0;
    int checks = 0;
    int model_last = 2;

    snoop_bus_ctrl #(.SNOOP_LAT(LAT), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_msg0   (req_msg0),
        .req_msg1   (req_msg1),
        .req_msg2   (req_msg2),
        .snoop0     (snoop0),
        .snoop1     (snoop1),
        .snoop2     (snoop2),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .gnt        (gnt),
        .processor  (processor),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_src   (resp_src),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick_winner(input logic [2:0] r, input int last);
        int i;
        for (int k = 1; k <= 3; k++) begin
            i = (last + k) % 3;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int find_supplier(input logic [11:0] s0, input logic [11:0] s1,
                                         input logic [11:0] s2, input int owner);
        logic [11:0] s [3];
        s[0] = s0; s[1] = s1; s[2] = s2;
        for (int i = 0; i < 3; i++)
            if (i != owner && s[i][10] && s[i][9:8] != 2'b00) return i;
        return -1;
    endfunction

    // Starts and ends on a falling edge with the DUT idle.
    task automatic run_txn(input logic [2:0] r, input logic [11:0] m0, input logic [11:0] m1,
                           input logic [11:0] m2, input logic [11:0] s0, input logic [11:0] s1,
                           input logic [11:0] s2, input int d, input logic [11:0] md);
        int          w, sup;
        logic [11:0] c, exp_data;
        logic [2:0]  eg;
        logic [1:0]  exp_src;
        w  = pick_winner(r, model_last);
        c  = (w == 0) ? m0 : (w == 1) ? m1 : m2;
        eg = 3'b001 << w;
        sup = find_supplier(s0, s1, s2, w);
        req = r; req_msg0 = m0; req_msg1 = m1; req_msg2 = m2;
        snoop0 = s0; snoop1 = s1; snoop2 = s2; mem_ready = 1'b0;
        @(negedge clk);
        expect_eq("grant_gnt", 32'(gnt), 32'(eg));
        expect_eq("grant_proc", 32'(processor), 32'(w));
        expect_eq("grant_cmd", 32'(cmd), 32'(c));
        expect_eq("grant_cmd_valid", 32'(cmd_valid), 32'd1);
        req = 3'($urandom);
        mem_ready = 1'($urandom);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            expect_eq("snoop_cmd_valid", 32'(cmd_valid), 32'd0);
            expect_eq("snoop_mem_req", 32'(mem_req), 32'd0);
            expect_eq("snoop_gnt", 32'(gnt), 32'(eg));
            mem_ready = 1'($urandom);
        end
        @(negedge clk);
        if (!c[11] && sup >= 0) begin
            exp_data = (sup == 0) ? s0 : (sup == 1) ? s1 : s2;
            exp_src  = 2'(sup);
        end else begin
            exp_data = c[11] ? c : md;
            exp_src  = 2'b11;
            expect_eq("mem_req_rise", 32'(mem_req), 32'd1);
            expect_eq("mem_we", 32'(mem_we), 32'(c[11]));
            expect_eq("mem_no_resp", 32'(resp_valid), 32'd0);
            for (int i = 0; i <= d; i++) begin
                mem_ready = (i == d);
                mem_data  = (i == d) ? md : 12'($urandom);
                @(negedge clk);
                if (i < d) begin
                    expect_eq("mem_req_hold", 32'(mem_req), 32'd1);
                    expect_eq("mem_wait_resp", 32'(resp_valid), 32'd0);
                end
            end
            mem_ready = 1'b0;
        end
        expect_eq("resp_valid", 32'(resp_valid), 32'd1);
        expect_eq("resp_data", 32'(resp_data), 32'(exp_data));
        expect_eq("resp_src", 32'(resp_src), 32'(exp_src));
        expect_eq("resp_err", 32'(resp_err), 32'd0);
        expect_eq("resp_mem_req", 32'(mem_req), 32'd0);
        expect_eq("resp_gnt", 32'(gnt), 32'(eg));
        mem_ready = 1'($urandom);
        @(negedge clk);
        expect_eq("done_gnt", 32'(gnt), 32'd0);
        expect_eq("done_proc", 32'(processor), 32'd3);
        expect_eq("done_resp_valid", 32'(resp_valid), 32'd0);
        model_last = w;
        @(negedge clk);
        expect_eq("idle_gnt", 32'(gnt), 32'd0);
        expect_eq("idle_cmd_valid", 32'(cmd_valid), 32'd0);
        mem_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mem_ready = 1'b0; mem_data = '0;
        req_msg0 = '0; req_msg1 = '0; req_msg2 = '0;
        snoop0 = '0; snoop1 = '0; snoop2 = '0;
        @(negedge clk);
        expect_eq("rst_proc", 32'(processor), 32'd3);
        expect_eq("rst_gnt", 32'(gnt), 32'd0);
        expect_eq("rst_strobes", 32'({cmd_valid, mem_req, mem_we, resp_valid, resp_err}), 32'd0);
        expect_eq("rst_resp", 32'({resp_data, resp_src, cmd}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All three requesting: grant order 0,1,2,0.
        for (int t = 0; t < 4; t++)
            run_txn(3'b111, 12'h011, 12'h022, 12'h033, 12'h0, 12'h0, 12'h0, 0, 12'h100 + 12'(t));

        run_txn(3'b001, 12'h044, 12'h0, 12'h0, 12'h0, 12'h5A5, 12'h0, 0, 12'h0);
        run_txn(3'b001, 12'h055, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 0, 12'h0);
        run_txn(3'b001, 12'h066, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 0, 12'h0);
        run_txn(3'b001, 12'h077, 12'h0, 12'h0, 12'h4C1, 12'h0, 12'h7D2, 0, 12'h0);
        run_txn(3'b010, 12'h0, 12'h088, 12'h0, 12'h0, 12'h5A5, 12'h0, 2, 12'h3C3);
        run_txn(3'b100, 12'h0, 12'h0, 12'h099, 12'h0, 12'h0, 12'h0, 5, 12'h0A5);
        run_txn(3'b010, 12'h0, 12'h0AA, 12'h0, 12'h0, 12'h0, 12'h0, TMO - 1, 12'h6E6);
        run_txn(3'b100, 12'h0, 12'h0, 12'h8C3, 12'h5FF, 12'h5FF, 12'h5FF, 1, 12'h123);

        // Write, then reset while memory is outstanding.
        req = 3'b001; req_msg0 = 12'h8C3; snoop0 = '0; snoop1 = '0; snoop2 = '0;
        @(negedge clk);
        expect_eq("wr_cmd", 32'(cmd), 32'h8C3);
        req = '0;
        for (int k = 0; k < LAT; k++) @(negedge clk);
        @(negedge clk);
        expect_eq("wr_mem_req", 32'(mem_req), 32'd1);
        expect_eq("wr_mem_we", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        expect_eq("arst_mem_req", 32'(mem_req), 32'd0);
        expect_eq("arst_proc", 32'(processor), 32'd3);
        expect_eq("arst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            expect_eq("arst_no_resp", 32'({resp_valid, mem_req, cmd_valid}), 32'd0);
        end

`ifdef SNOOP_BUS_TIMEOUT_EN
        req = 3'b010; req_msg1 = 12'h012; mem_ready = 1'b0;
        @(negedge clk);
        req = '0;
        for (int k = 0; k < LAT; k++) @(negedge clk);
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            expect_eq("tmo_mem_req", 32'(mem_req), 32'd1);
            expect_eq("tmo_wait_resp", 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        expect_eq("tmo_resp_valid", 32'(resp_valid), 32'd1);
        expect_eq("tmo_resp_err", 32'(resp_err), 32'd1);
        expect_eq("tmo_resp_data", 32'(resp_data), 32'd0);
        expect_eq("tmo_resp_src", 32'(resp_src), 32'd3);
        expect_eq("tmo_mem_req_drop", 32'(mem_req), 32'd0);
        @(negedge clk);
        expect_eq("tmo_err_pulse", 32'(resp_err), 32'd0);
        model_last = 1;
        @(negedge clk);
`endif

        for (int t = 0; t < 40; t++) begin
            logic [2:0] r;
            r = 3'($urandom_range(1, 7));
            run_txn(r, 12'($urandom), 12'($urandom), 12'($urandom),
                    12'($urandom), 12'($urandom), 12'($urandom),
                    int'($urandom_range(0, TMO - 1)), 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snoop_bus_ctrl.md
# snoop_bus_ctrl

Transaction sequencer and arbiter for the shared snooping bus of the three-processor coherence system. It grants the bus to one cache controller at a time (round-robin), broadcasts the winner's command to the snoopers, and picks the data source: the lowest-index supplying cache, or memory through a ready handshake. It returns one response to the requester. It drives the owner-id select consumed by the response data multiplexer.

## Interface
- SNOOP_LAT, 1: cycles in SNOOP before snoop words are sampled (1..7).
- TIMEOUT_CYC, 64: memory wait limit; used only when the timeout macro is defined.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  3  per-processor bus request; level, bit i = processor i.
- req_msg0, req_msg1, req_msg2  in  12  command word from each processor.
- snoop0, snoop1, snoop2  in  12  snoop response word from each cache.
- mem_data  in  12  memory read word.
- mem_ready  in  1  memory completion strobe.
- gnt  out  3  one-hot grant.
- processor  out  2  owner id; 2'b11 when no owner.
- cmd  out  12  latched command of the owner.
- cmd_valid  out  1  one-cycle broadcast strobe.
- mem_req  out  1  memory access request, held until mem_ready.
- mem_we  out  1  qualifies mem_req as a write.
- resp_valid  out  1  one-cycle response strobe to the owner.
- resp_data  out  12  response word.
- resp_src  out  2  0..2 = supplying cache, 2'b11 = memory.
- resp_err  out  1  timeout error; tied 0 without the macro.

## Operation
- Word fields:
  - [11] op: 0 = read, 1 = write.
  - [10] supply flag.
  - [9:8] coherence state; 00 = invalid.
  - [7:0] address/data.
- A cache supplies when [10]=1, [9:8]!=00, and it is not the owner.
- States are IDLE, GRANT, SNOOP, MEM, RESP and DONE.
- IDLE: if any req bit is set, pick a winner round-robin starting at (last+1) mod 3, then go to GRANT.
- GRANT (1 cycle):
  - gnt and processor are set for the winner.
  - cmd latches the winner's req_msg.
  - cmd_valid=1.
  - Next state is SNOOP.
- SNOOP:
  - Wait SNOOP_LAT cycles, then evaluate the snoop words on the last cycle.
  - Read with a supplier: fixed priority 0 > 1 > 2. resp_data = that snoop word, resp_src = its index. Go to RESP.
  - Read without a supplier: go to MEM with mem_we=0.
  - Write: go to MEM with mem_we=1 and mem data = cmd; snoop results are ignored.
- MEM:
  - mem_req=1 until mem_ready is sampled high.
  - Read: resp_data = mem_data as sampled with mem_ready.
  - Write: resp_data = cmd.
  - resp_src = 2'b11. Go to RESP.
- RESP (1 cycle): resp_valid=1, then go to DONE.
- DONE (1 cycle):
  - gnt=0, processor=2'b11.
  - The round-robin pointer is updated to the owner.
  - Next state is IDLE.
- The owner dropping req mid-transaction does not abort it; the transaction completes.
- mem_ready outside MEM is ignored.

## Timing
- Reset values:
  - All outputs 0, except processor = 2'b11.
  - State IDLE; round-robin pointer last = 2, so processor 0 wins first.
- Reset assertion mid-transaction returns to IDLE immediately. No response is issued, and mem_req drops asynchronously.
- Read hit latency (SNOOP_LAT=1):
  - req seen in IDLE at cycle 0.
  - gnt and cmd_valid in cycle 1.
  - SNOOP in cycle 2.
  - resp_valid in cycle 3.
  - DONE in cycle 4.
  - Earliest next grant in cycle 6.
- Memory path: mem_req rises in the cycle after SNOOP ends. resp_valid comes 1 cycle after mem_ready is sampled.
- Simultaneous requests are resolved strictly round-robin. No requester waits more than 2 transactions.
- gnt is registered, one-hot, and stable from GRANT through RESP.

## Configuration
- SNOOP_BUS_TIMEOUT_EN defined:
  - A counter runs in MEM.
  - If TIMEOUT_CYC cycles pass without mem_ready, the block drops mem_req and goes to RESP with resp_err=1, resp_data=0 and resp_src=2'b11.
  - mem_ready arriving on the same cycle as the timeout wins; no error is flagged.
- SNOOP_BUS_TIMEOUT_EN undefined: MEM waits indefinitely and resp_err is constant 0.

## Structure
- Shared package snoop_pkg:
  - Word field positions.
  - Op codes.
  - Coherence state encoding, with INVALID = 2'b00.
  - PROC_NONE = 2'b11.
  - The controller state enum.
- Sub-module rr_arbiter3: 3 requests and a last-grant pointer in, a one-hot winner out. Purely combinational.

## Test plan
- Reset → processor=2'b11, gnt=0, all strobes 0. Apply req=3'b111 → gnts in order 001, 010, 100, 001.
- Read with snoop1=12'h5xx ([10]=1, state 01), owner 0 → resp_valid in cycle 3, resp_data=snoop1, resp_src=1, mem_req never high.
- Read with snoop0 and snoop2 both supplying, owner 0 → resp_src=2.
- Owner 1 with snoop1 supplying is ignored → memory path; resp_src=3.
- Read miss with mem_ready 5 cycles after mem_req, mem_data=12'h0A5 → resp_data=12'h0A5, resp_src=3.
- Write cmd=12'h8C3 → mem_req=1 with mem_we=1. rst_n pulse mid-MEM → mem_req=0, processor=2'b11, no resp_valid.
- With SNOOP_BUS_TIMEOUT_EN, TIMEOUT_CYC=8 and mem_ready held low → resp_err=1 and resp_data=0 after 8 MEM cycles.
